fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 32 +++
 rtl/fetch_queue_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared pipeline typedefs: pipeline registers, fetch FSM state, fetch-queue entry
package fetch_queue_pkg;

    // Widths of the default pipeline configuration
    localparam int unsigned PIPE_PC_W  = 9;
    localparam int unsigned PIPE_INS_W = 32;

    // Fetch-to-decode pipeline register
    typedef struct packed {
        logic                  valid;
        logic [PIPE_PC_W-1:0]  pc;
        logic [PIPE_INS_W-1:0] instr;
    } if_id_reg_t;

    // Fetch FSM: IDLE stops new fetches, RUN issues one fetch per cycle when room exists
    typedef enum logic [0:0] {
        FQ_IDLE = 1'b0,
        FQ_RUN  = 1'b1
    } fq_state_e;

    // One fetch-queue entry, pc in the upper bits and instr in the lower bits
    typedef struct packed {
        logic [PIPE_PC_W-1:0]  pc;
        logic [PIPE_INS_W-1:0] instr;
    } fq_entry_t;

    // Packed width of a {pc, instr} entry for arbitrary widths
    function automatic int unsigned fq_entry_w(input int unsigned pc_w, input int unsigned ins_w);
        return pc_w + ins_w;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - fetch_fifo: power-of-two circular buffer with push/pop/flush and occupancy count
module fetch_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Head entry is read combinationally so decode sees it in the cycle it becomes valid
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush and reset empty the queue
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with decoupling queue; FETCH_QUEUE_PERF_EN adds fetch/flush counters
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int PC_W     = 9,
    parameter int INS_W    = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INS_W-1:0]           imem_rdata,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INS_W-1:0]           out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                fetch_cnt,
    output logic [31:0]                flush_cnt
`endif
);

    localparam int            CW   = $clog2(DEPTH+1);
    localparam int            EW   = fq_entry_w(PC_W, INS_W);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fq_state_e         r_state;
    logic [PC_W-1:0]   r_pc;
    logic [CW-1:0]     w_count;
    logic [EW-1:0]     w_head;
    logic              w_pop;
    logic              w_push;
    logic              w_full;

    assign imem_addr = r_pc;
    assign count     = w_count;
    assign out_pc    = w_head[EW-1:INS_W];
    assign out_instr = w_head[INS_W-1:0];

    // A redirect squashes the head presentation and any push in the same cycle
    assign out_valid = (w_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign w_full    = (w_count == FULL);
    assign w_push    = (r_state == FQ_RUN) && !redirect_valid && (!w_full || w_pop);

    // Fetch enable FSM; redirect does not change the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FQ_IDLE;
        end else begin
            r_state <= fetch_en ? FQ_RUN : FQ_IDLE;
        end
    end

    // Fetch PC: redirect target wins over sequential advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= PC_W'(RESET_PC);
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + PC_W'(4);
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_pc, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_pop_data  (w_head),
        .o_count     (w_count)
    );

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;

    // Free-running perf counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_push)         r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (redirect_valid) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INS_W-1:0]  imem_rdata;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INS_W-1:0]  out_instr;
    logic [2:0]        count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                m_run;
    logic [PC_W-1:0]   m_pc;
    logic [PC_W-1:0]   mq_pc[$];
    logic [INS_W-1:0]  mq_ins[$];
    logic [31:0]       m_fetch;
    logic [31:0]       m_flush;
    bit                d_pop;
    bit                d_push;

    always #5 clk = ~clk;

    function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] pc);
        return {7'h55, pc, ~pc, pc[6:0]};
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    fetch_queue #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_pc    = '0;
        mq_pc.delete();
        mq_ins.delete();
        m_fetch = '0;
        m_flush = '0;
    endtask

    // Mid-cycle: compare outputs with the model and decide this cycle's push/pop
    task automatic settle();
        bit ov;
        @(negedge clk);
        ov = (mq_pc.size() > 0) && !redirect_valid;
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        chk("count", 64'(count), 64'(mq_pc.size()));
        chk("out_valid", 64'(out_valid), 64'(ov));
        if (mq_pc.size() > 0) begin
            chk("out_pc", 64'(out_pc), 64'(mq_pc[0]));
            chk("out_instr", 64'(out_instr), 64'(mq_ins[0]));
        end
`ifdef FETCH_QUEUE_PERF_EN
        chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
        d_pop  = ov && out_ready;
        d_push = m_run && !redirect_valid && (mq_pc.size() < DEPTH || d_pop);
    endtask

    // Clock edge: apply the decided transition to the model
    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (redirect_valid) begin
                mq_pc.delete();
                mq_ins.delete();
                m_pc = redirect_pc;
                m_flush++;
            end else begin
                if (d_pop) begin
                    void'(mq_pc.pop_front());
                    void'(mq_ins.pop_front());
                end
                if (d_push) begin
                    mq_pc.push_back(m_pc);
                    mq_ins.push_back(instr_of(m_pc));
                    m_pc = m_pc + PC_W'(4);
                    m_fetch++;
                end
            end
            m_run = fetch_en;
        end
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state and sequential fetch with decode always ready
        step();
        rst       = 1'b0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("seq_valid", 64'(out_valid), 64'd1);
            chk("seq_pc", 64'(out_pc), 64'(k * 4));
            advance();
        end

        // Decode stalled: queue saturates, fetch PC holds
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        repeat (6) step();
        settle();
        chk("stall_count", 64'(count), 64'd4);
        chk("stall_addr", 64'(imem_addr), 64'h10);
        chk("stall_pc", 64'(out_pc), 64'h0);
        advance();

        // Full queue with decode ready: push and pop together
        out_ready = 1'b1;
        settle();
        advance();
        settle();
        chk("full_count", 64'(count), 64'd4);
        chk("full_addr", 64'(imem_addr), 64'h14);
        chk("full_pc", 64'(out_pc), 64'h4);
        advance();

        // Reach count=3 with state RUN, then redirect
        fetch_en  = 1'b0;
        out_ready = 1'b0;
        step();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 9'h040;
        settle();
        chk("redir_count_pre", 64'(count), 64'd3);
        chk("redir_valid", 64'(out_valid), 64'd0);
        advance();
        redirect_valid = 1'b0;
        settle();
        chk("redir_count", 64'(count), 64'd0);
        chk("redir_addr", 64'(imem_addr), 64'h40);
        advance();
        settle();
        chk("redir_head_valid", 64'(out_valid), 64'd1);
        chk("redir_head_pc", 64'(out_pc), 64'h40);
        advance();

        // PC wrap at 2^PC_W
        redirect_valid = 1'b1;
        redirect_pc    = 9'h1FC;
        step();
        redirect_valid = 1'b0;
        settle();
        chk("wrap_addr_pre", 64'(imem_addr), 64'h1FC);
        advance();
        settle();
        chk("wrap_addr", 64'(imem_addr), 64'h000);
        chk("wrap_head", 64'(out_pc), 64'h1FC);
        advance();

        // Reset dominates a redirect with two entries queued
        redirect_valid = 1'b1;
        redirect_pc    = 9'h100;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        step();
        step();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 9'h0A0;
        settle();
        chk("rst_count_pre", 64'(count), 64'd2);
        advance();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        settle();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'h0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        advance();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = PC_W'($urandom);
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            step();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
